// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch PC, single-outstanding instruction read and instruction FIFO
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_drain_addr;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_has_space;
  logic          w_unused_rpc_lsb;

  // Low address bits of a redirect target are forced to zero, so they are not stored.
  assign w_unused_rpc_lsb = ^redirect_pc[1:0];

  // A redirect flushes everything: the same-cycle response and pop are both dropped.
  assign w_push      = (r_state == S_REQ) && mem_resp && !redirect;
  assign w_pop       = (r_count != '0) && instr_ready && !redirect;
  assign w_count_nxt = redirect ? '0
                     : r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  // A request is only started when its response is guaranteed a slot.
  assign w_has_space = (w_count_nxt < FULL_CNT);

  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_instr[r_rptr];
  assign instr_pc    = r_fifo_pc[r_rptr];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and memory port outputs; DRAIN keeps the abandoned address on the bus.
  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_address = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (!redirect && fetch_en && w_has_space) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_read = 1'b1;
        if (redirect) begin
          w_state_nxt = mem_resp ? S_IDLE : S_DRAIN;
        end else if (mem_resp) begin
          w_state_nxt = (fetch_en && w_has_space) ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        mem_read    = 1'b1;
        mem_address = r_drain_addr;
        if (mem_resp) begin
          w_state_nxt = (!redirect && fetch_en && w_has_space) ? S_REQ : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Fetch PC advances on each accepted word and jumps on redirect; drain address latches the abandoned read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if ((r_state == S_REQ) && redirect && !mem_resp) begin
        r_drain_addr <= r_fetch_pc;
      end
    end
  end

  // FIFO storage: written only on push, head read directly from the registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_fifo_instr[r_wptr] <= mem_rdata;
      r_fifo_pc[r_wptr]    <= r_fetch_pc;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (redirect) begin
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h4000_0060;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic        fe;
    logic        rsp;
    logic [31:0] rdata;
    logic        rdy;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  // Reference model: expected instruction stream and next fetch address.
  entry_t      q[$];
  logic [31:0] exp_pc;
  logic        m_busy;
  logic        stale;
  int          m_wait;
  int          m_lat;
  logic [31:0] m_addr;
  bit          rand_lat;
  int          fixed_lat;
  logic        prev_fe;
  logic        prev_redir;
  logic [31:0] req_log[$];
  int          n_resp;
  int          n_pops;
  int          n0;
  logic        g_fe;
  logic        g_rdy;
  logic        g_redir;
  logic [31:0] g_rpc;
  vec_t        tv[11];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(input logic fe, input logic rsp, input logic rdy, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.fe        = fe;
    v.rsp       = rsp;
    v.rdata     = rsp ? data_of(ea) : 32'h0;
    v.rdy       = rdy;
    v.exp_read  = er;
    v.exp_addr  = ea;
    v.exp_valid = ev;
    v.exp_pc    = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    req_log.delete();
    exp_pc     = RESET_PC;
    m_busy     = 1'b0;
    stale      = 1'b0;
    m_wait     = 0;
    m_lat      = 0;
    m_addr     = 32'h0;
    prev_fe    = 1'b0;
    prev_redir = 1'b0;
    n_resp     = 0;
    n_pops     = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_resp    = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    g_fe        = 1'b0;
    g_rdy       = 1'b0;
    g_redir     = 1'b0;
    g_rpc       = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_address", mem_address, RESET_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    rst = 1'b1;
    model_reset();
  endtask

  // One clock: memory responder, apply inputs, advance the model, then check after the edge.
  task automatic step();
    logic   rsp;
    logic   pop;
    logic   discard;
    entry_t e;
    rsp = 1'b0;
    if (mem_read) begin
      if (!m_busy) begin
        m_busy = 1'b1;
        m_wait = 0;
        m_addr = mem_address;
        m_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        req_log.push_back(mem_address);
        chk("req_addr", mem_address, exp_pc);
        chk("req_slot_free", 32'(q.size() < DEPTH), 32'd1);
        chk("req_permitted", 32'(prev_fe && !prev_redir), 32'd1);
      end else begin
        chk("addr_stable", mem_address, m_addr);
      end
      if (m_wait >= m_lat) rsp = 1'b1;
      else m_wait++;
    end else if (m_busy) begin
      chk("read_dropped", 32'(mem_read), 32'd1);
      m_busy = 1'b0;
    end

    mem_resp    = rsp;
    mem_rdata   = rsp ? data_of(m_addr) : $urandom();
    fetch_en    = g_fe;
    instr_ready = g_rdy;
    redirect    = g_redir;
    redirect_pc = g_rpc;

    pop = instr_valid && g_rdy && !g_redir;
    if (pop && q.size() > 0) begin
      chk("pop_pc", instr_pc, q[0].pc);
      chk("pop_instr", instr, q[0].data);
      void'(q.pop_front());
      n_pops++;
    end
    discard = g_redir || stale;
    if (g_redir) begin
      q.delete();
      exp_pc = {g_rpc[31:2], 2'b00};
    end
    if (rsp) begin
      m_busy = 1'b0;
      n_resp++;
      if (!discard) begin
        chk("push_not_full", 32'(q.size() < DEPTH), 32'd1);
        e.pc   = m_addr;
        e.data = data_of(m_addr);
        q.push_back(e);
        exp_pc = m_addr + 32'd4;
      end
      stale = 1'b0;
    end else if (g_redir && m_busy) begin
      stale = 1'b1;
    end
    prev_fe    = g_fe;
    prev_redir = g_redir;

    @(posedge clk);
    @(negedge clk);
    chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (instr_valid && q.size() != 0) begin
      chk("head_pc", instr_pc, q[0].pc);
      chk("head_instr", instr, q[0].data);
    end
  endtask

  initial begin
    // Reset release, fetch_en=1, response two cycles after each request starts, consumer always ready.
    tv[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h4000_0060, 1'b0, 32'h0);
    tv[1]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0060, 1'b0, 32'h0);
    tv[2]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0060, 1'b0, 32'h0);
    tv[3]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h4000_0060, 1'b0, 32'h0);
    tv[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0064, 1'b1, 32'h4000_0060);
    tv[5]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0064, 1'b0, 32'h0);
    tv[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h4000_0064, 1'b0, 32'h0);
    tv[7]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0068, 1'b1, 32'h4000_0064);
    tv[8]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_0068, 1'b0, 32'h0);
    tv[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h4000_0068, 1'b0, 32'h0);
    tv[10] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_006C, 1'b1, 32'h4000_0068);

    rand_lat  = 1'b0;
    fixed_lat = 0;

    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tv%0d_mem_read", i), 32'(mem_read), 32'(tv[i].exp_read));
      chk($sformatf("tv%0d_mem_address", i), mem_address, tv[i].exp_addr);
      chk($sformatf("tv%0d_instr_valid", i), 32'(instr_valid), 32'(tv[i].exp_valid));
      if (tv[i].exp_valid) begin
        chk($sformatf("tv%0d_instr_pc", i), instr_pc, tv[i].exp_pc);
        chk($sformatf("tv%0d_instr", i), instr, data_of(tv[i].exp_pc));
      end
      fetch_en    = tv[i].fe;
      mem_resp    = tv[i].rsp;
      mem_rdata   = tv[i].rdata;
      instr_ready = tv[i].rdy;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      @(posedge clk);
      @(negedge clk);
    end

    // Backpressure: exactly DEPTH reads complete, then fetch stalls until the consumer drains.
    do_reset();
    fixed_lat = 0;
    g_fe      = 1'b1;
    g_rdy     = 1'b0;
    repeat (8) step();
    chk("bp_reads_done", 32'(n_resp), 32'(DEPTH));
    chk("bp_mem_read_idle", 32'(mem_read), 32'd0);
    chk("bp_instr_valid", 32'(instr_valid), 32'd1);
    g_rdy = 1'b1;
    for (int i = 0; i < 20 && req_log.size() < 3; i++) step();
    chk("bp_resume_addr", (req_log.size() >= 3) ? req_log[2] : 32'hDEAD_BEEF, 32'h4000_0068);

    // Redirect while the read of 0x...64 is outstanding: drain it, then restart at the target.
    do_reset();
    fixed_lat = 3;
    g_fe      = 1'b1;
    g_rdy     = 1'b1;
    for (int i = 0; i < 20 && req_log.size() < 2; i++) step();
    chk("rd_second_req", (req_log.size() == 2) ? req_log[1] : 32'hDEAD_BEEF, 32'h4000_0064);
    g_redir = 1'b1;
    g_rpc   = 32'h4000_1003;
    step();
    g_redir = 1'b0;
    chk("rd_drain_read", 32'(mem_read), 32'd1);
    chk("rd_drain_addr", mem_address, 32'h4000_0064);
    chk("rd_fifo_empty", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 20 && req_log.size() < 3; i++) begin
      step();
      chk("rd_empty_during_drain", 32'(instr_valid && req_log.size() < 3), 32'd0);
    end
    chk("rd_target", (req_log.size() >= 3) ? req_log[2] : 32'hDEAD_BEEF, 32'h4000_1000);

    // Redirect in the same cycle as mem_resp and a pop: no push, no drain.
    do_reset();
    fixed_lat = 0;
    g_fe      = 1'b1;
    g_rdy     = 1'b0;
    for (int i = 0; i < 20 && !(mem_read && instr_valid); i++) step();
    chk("rp_setup", 32'(mem_read && instr_valid), 32'd1);
    g_redir = 1'b1;
    g_rpc   = 32'h4000_2000;
    g_rdy   = 1'b1;
    n0      = n_resp;
    step();
    g_redir = 1'b0;
    chk("rp_resp_same_cycle", 32'(n_resp - n0), 32'd1);
    chk("rp_no_drain", 32'(mem_read), 32'd0);
    chk("rp_flushed", 32'(instr_valid), 32'd0);
    req_log.delete();
    for (int i = 0; i < 20 && req_log.size() < 1; i++) step();
    chk("rp_target", (req_log.size() >= 1) ? req_log[0] : 32'hDEAD_BEEF, 32'h4000_2000);

    // Asynchronous reset between edges while a read is outstanding and the FIFO is non-empty.
    do_reset();
    fixed_lat = 2;
    g_fe      = 1'b1;
    g_rdy     = 1'b0;
    for (int i = 0; i < 20 && !(mem_read && instr_valid); i++) step();
    chk("ar_setup", 32'(mem_read && instr_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_mem_read", 32'(mem_read), 32'd0);
    chk("ar_instr_valid", 32'(instr_valid), 32'd0);
    chk("ar_mem_address", mem_address, RESET_PC);
    do_reset();
    g_fe  = 1'b1;
    g_rdy = 1'b1;
    for (int i = 0; i < 20 && req_log.size() < 1; i++) step();
    chk("ar_restart", (req_log.size() >= 1) ? req_log[0] : 32'hDEAD_BEEF, RESET_PC);

    // Fetch PC wrap from 0xFFFF_FFFC (unaligned redirect target) to 0.
    do_reset();
    fixed_lat = 0;
    g_fe      = 1'b1;
    g_rdy     = 1'b1;
    g_redir   = 1'b1;
    g_rpc     = 32'hFFFF_FFFE;
    step();
    g_redir = 1'b0;
    for (int i = 0; i < 30 && req_log.size() < 2; i++) step();
    chk("wrap_first", (req_log.size() >= 1) ? req_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_next", (req_log.size() >= 2) ? req_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Randomized traffic against the reference model.
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      g_fe    = ($urandom_range(0, 9) < 8);
      g_rdy   = ($urandom_range(0, 9) < 6);
      g_redir = ($urandom_range(0, 99) < 4);
      g_rpc   = $urandom();
      step();
    end
    chk("rand_progress", 32'(n_pops > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
